axi_lite_arbiter: RTL and testbench
===================================

AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter
Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width in bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, address width in bits.
REQ-004 SHALL have port axi_aclk  in  1  single clock, rising edge.
REQ-005 SHALL have port axi_areset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  in  NUM_REQ  per-requester command pending.
REQ-007 SHALL have port req_we  in  NUM_REQ  per-requester 1=write, 0=read.
REQ-008 SHALL have port req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at slice i.
REQ-009 SHALL have port req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
REQ-010 SHALL have port req_ready  out  NUM_REQ  one-hot grant/accept pulse.
REQ-011 SHALL have port rsp_valid  out  NUM_REQ  one-hot completion pulse.
REQ-012 SHALL have port rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid.
REQ-013 SHALL have port rsp_err  out  1  1 when bresp/rresp != OKAY, valid with rsp_valid.
REQ-014 SHALL have AXI-Lite master ports m0_axi_awaddr out ADDR_WIDTH, m0_axi_awvalid out 1, m0_axi_awready in 1.
REQ-015 SHALL have m0_axi_wdata out DATA_WIDTH, m0_axi_wstrb out DATA_WIDTH/8, m0_axi_wvalid out 1, m0_axi_wready in 1.
REQ-016 SHALL have m0_axi_bresp in 2, m0_axi_bvalid in 1, m0_axi_bready out 1.
REQ-017 SHALL have m0_axi_araddr out ADDR_WIDTH, m0_axi_arvalid out 1, m0_axi_arready in 1.
REQ-018 SHALL have m0_axi_rdata in DATA_WIDTH, m0_axi_rresp in 2, m0_axi_rvalid in 1, m0_axi_rready out 1.
Function
REQ-019 SHALL run FSM IDLE -> (WR_AW_W -> WR_B | RD_AR -> RD_R) -> DONE -> IDLE; exactly one transaction outstanding.
REQ-020 SHALL, in IDLE with any req_valid, grant one requester: req_ready[g]=1 for exactly one cycle; latch addr, wdata, we, g.
REQ-021 SHALL use round-robin: search starts at (last_grant+1) mod NUM_REQ; simultaneous requests are resolved by this order only.
REQ-022 SHALL assert awvalid and wvalid together in the cycle after grant; each drops independently on its own handshake; WR_B entered when both done (same or different cycles).
REQ-023 SHALL hold awaddr/wdata/araddr stable while valid is high; wstrb all ones.
REQ-024 SHALL assert bready only in WR_B and rready only in RD_R; capture rdata/resp on handshake.
REQ-025 SHALL in DONE pulse rsp_valid[g] one cycle with rsp_rdata (0 for writes) and rsp_err; minimum latency grant-to-rsp = 3 cycles with zero-wait slave.
REQ-026 SHALL ignore req_valid deassertion before grant; requester dropping after grant does not abort transaction.
REQ-027 SHALL never grant in the DONE cycle; next grant earliest the cycle after DONE.
Reset
REQ-028 SHALL on axi_areset force immediately: state IDLE, all valid/ready/rsp outputs 0, data outputs 0, last_grant=NUM_REQ-1 (requester 0 first); mid-transaction abort without response.
Configuration
REQ-029 SHALL with macro AXI_ARB_FIXED_PRIORITY_EN defined use fixed priority (lowest index wins, last_grant unused); without it use round-robin per REQ-021.
Structure
REQ-030 SHALL place state enum arb_state_t and RESP_OKAY/RESP_SLVERR constants in package axi_arb_pkg; grant selection in sub-module rr_arbiter.
Verification
REQ-031 Req0 write addr 0x10 data 0xDEADBEEF, zero-wait slave -> AW/W at cycle+1, rsp_valid[0] at cycle+3, rsp_err=0.
REQ-032 Req0 and req1 read continuously -> grants alternate 0,1,0,1; with AXI_ARB_FIXED_PRIORITY_EN -> always 0.
REQ-033 awready at +1, wready delayed 4 cycles -> awvalid drops at +1, wvalid held until +5, bready only afterwards.
REQ-034 Read addr 0x20, rresp=SLVERR, rdata=0x12345678 -> rsp_err=1, rsp_rdata=0x12345678, rsp_valid[g] one cycle.
REQ-035 axi_areset asserted in WR_B -> all outputs 0 same cycle, no rsp_valid, next grant goes to requester 0.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and response codes for the AXI-Lite request arbiter.
// Optional build macro used by this slice: AXI_ARB_FIXED_PRIORITY_EN.
package axi_arb_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_WR_AW_W = 3'd1,
    ARB_WR_B    = 3'd2,
    ARB_RD_AR   = 3'd3,
    ARB_RD_R    = 3'd4,
    ARB_DONE    = 3'd5
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Anything other than a plain OKAY, including EXOKAY, is reported as an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant selection: round-robin from last_grant+1, or fixed
// priority (lowest index wins) when AXI_ARB_FIXED_PRIORITY_EN is defined.
module rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef AXI_ARB_FIXED_PRIORITY_EN
      cand = IDX_W'(i);
`else
      cand = IDX_W'((int'(last_grant) + 1 + i) % NUM_REQ);
`endif
      if (!any && req[cand]) begin
        any       = 1'b1;
        grant_idx = cand;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (any && grant_idx == IDX_W'(i)) grant[i] = 1'b1;
    end
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Arbitrates NUM_REQ simple command ports onto one AXI-Lite master, one
// transaction at a time. Build macro: AXI_ARB_FIXED_PRIORITY_EN (fixed priority).
//   state       | meaning
//   ARB_IDLE    | waiting for any req_valid; grant pulse issued here
//   ARB_WR_AW_W | AW and W offered together, each retires on its own handshake
//   ARB_WR_B    | waiting for write response
//   ARB_RD_AR   | read address offered
//   ARB_RD_R    | waiting for read data
//   ARB_DONE    | one-cycle rsp_valid pulse to the granted requester
module axi_lite_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                          axi_aclk,
  input  logic                          axi_areset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic [ADDR_WIDTH-1:0]         m0_axi_awaddr,
  output logic                          m0_axi_awvalid,
  input  logic                          m0_axi_awready,
  output logic [DATA_WIDTH-1:0]         m0_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]       m0_axi_wstrb,
  output logic                          m0_axi_wvalid,
  input  logic                          m0_axi_wready,
  input  logic [1:0]                    m0_axi_bresp,
  input  logic                          m0_axi_bvalid,
  output logic                          m0_axi_bready,
  output logic [ADDR_WIDTH-1:0]         m0_axi_araddr,
  output logic                          m0_axi_arvalid,
  input  logic                          m0_axi_arready,
  input  logic [DATA_WIDTH-1:0]         m0_axi_rdata,
  input  logic [1:0]                    m0_axi_rresp,
  input  logic                          m0_axi_rvalid,
  output logic                          m0_axi_rready
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t state, state_nxt;

  logic [IDX_W-1:0]      last_grant;
  logic [IDX_W-1:0]      gnt_idx_q;
  logic [IDX_W-1:0]      arb_idx;
  logic [NUM_REQ-1:0]    arb_gnt;
  logic                  arb_any;
  logic                  grant_fire;

  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  aw_done;
  logic                  w_done;

  logic                  aw_fire, w_fire, b_fire, ar_fire, r_fire;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (arb_gnt),
    .grant_idx  (arb_idx),
    .any        (arb_any)
  );

  // Reset gates the grant so req_ready is low the instant reset rises.
  assign grant_fire = (state == ARB_IDLE) && arb_any && !axi_areset;
  assign req_ready  = grant_fire ? arb_gnt : '0;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign m0_axi_awvalid = (state == ARB_WR_AW_W) && !aw_done;
  assign m0_axi_wvalid  = (state == ARB_WR_AW_W) && !w_done;
  assign m0_axi_bready  = (state == ARB_WR_B);
  assign m0_axi_arvalid = (state == ARB_RD_AR);
  assign m0_axi_rready  = (state == ARB_RD_R);
  assign m0_axi_awaddr  = addr_q;
  assign m0_axi_araddr  = addr_q;
  assign m0_axi_wdata   = wdata_q;
  assign m0_axi_wstrb   = '1;

  assign aw_fire = m0_axi_awvalid && m0_axi_awready;
  assign w_fire  = m0_axi_wvalid  && m0_axi_wready;
  assign b_fire  = m0_axi_bvalid  && m0_axi_bready;
  assign ar_fire = m0_axi_arvalid && m0_axi_arready;
  assign r_fire  = m0_axi_rvalid  && m0_axi_rready;

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx_q == IDX_W'(i)) rsp_valid[i] = (state == ARB_DONE);
    end
  end

  assign rsp_rdata = (state == ARB_DONE) ? rdata_q : '0;
  assign rsp_err   = (state == ARB_DONE) ? err_q   : 1'b0;

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:    if (grant_fire) state_nxt = sel_we ? ARB_WR_AW_W : ARB_RD_AR;
      ARB_WR_AW_W: if ((aw_done || aw_fire) && (w_done || w_fire)) state_nxt = ARB_WR_B;
      ARB_WR_B:    if (b_fire) state_nxt = ARB_DONE;
      ARB_RD_AR:   if (ar_fire) state_nxt = ARB_RD_R;
      ARB_RD_R:    if (r_fire) state_nxt = ARB_DONE;
      ARB_DONE:    state_nxt = ARB_IDLE;
      default:     state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state      <= ARB_IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      gnt_idx_q  <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_fire) begin
        last_grant <= arb_idx;
        gnt_idx_q  <= arb_idx;
        addr_q     <= sel_addr;
        wdata_q    <= sel_we ? sel_wdata : '0;
        rdata_q    <= '0;
        err_q      <= 1'b0;
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
      end
      if (aw_fire) aw_done <= 1'b1;
      if (w_fire)  w_done  <= 1'b1;
      if (b_fire)  err_q   <= resp_is_err(m0_axi_bresp);
      if (r_fire) begin
        rdata_q <= m0_axi_rdata;
        err_q   <= resp_is_err(m0_axi_rresp);
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter with a latency-programmable AXI-Lite slave
// and a response scoreboard.
module tb_axi_lite_arbiter;
  import axi_arb_pkg::*;

  localparam int NR = 2;
  localparam int DW = 32;
  localparam int AW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_we = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*DW-1:0]  req_wdata = '0;
  logic [NR-1:0]     req_ready, rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic [AW-1:0]     awaddr, araddr;
  logic              awvalid, wvalid, bready, arvalid, rready;
  logic [DW-1:0]     wdata;
  logic [DW/8-1:0]   wstrb;
  logic              awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
  logic [1:0]        bresp = 2'b00, rresp = 2'b00;
  logic [DW-1:0]     rdata = '0;

  int unsigned aw_lat = 0, w_lat = 0, b_lat = 0;
  int unsigned aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  logic [DW-1:0] slv_rdata = '0;
  logic [1:0]    slv_rresp = 2'b00, slv_bresp = 2'b00;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  axi_lite_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .axi_aclk(clk), .axi_areset(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m0_axi_awaddr(awaddr), .m0_axi_awvalid(awvalid), .m0_axi_awready(awready),
    .m0_axi_wdata(wdata), .m0_axi_wstrb(wstrb), .m0_axi_wvalid(wvalid), .m0_axi_wready(wready),
    .m0_axi_bresp(bresp), .m0_axi_bvalid(bvalid), .m0_axi_bready(bready),
    .m0_axi_araddr(araddr), .m0_axi_arvalid(arvalid), .m0_axi_arready(arready),
    .m0_axi_rdata(rdata), .m0_axi_rresp(rresp), .m0_axi_rvalid(rvalid), .m0_axi_rready(rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave: ready/response driven on the falling edge, sampled by the DUT on the next rise.
  always @(negedge clk) begin
    if (awvalid) begin awready = (aw_cnt >= aw_lat); aw_cnt++; end
    else begin awready = 1'b0; aw_cnt = 0; end
    if (wvalid) begin wready = (w_cnt >= w_lat); w_cnt++; end
    else begin wready = 1'b0; w_cnt = 0; end
    if (bready) begin bvalid = (b_cnt >= b_lat); b_cnt++; end
    else begin bvalid = 1'b0; b_cnt = 0; end
    arready = arvalid;
    rvalid  = rready;
    rdata   = slv_rdata;
    rresp   = slv_rresp;
    bresp   = slv_bresp;
  end

  // Response monitor: every rsp_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid !== '0) begin
      chk("done_no_grant", {62'd0, req_ready}, 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_rsp", {62'd0, rsp_valid}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_onehot", {62'd0, rsp_valid}, 64'd1 << e.idx);
        chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
        chk("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int model_last;
    int exp_g;
    bit got;
    model_last = NR - 1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valids", {58'd0, awvalid, wvalid, arvalid, bready, rready, rsp_err},
        64'd0);
    chk("rst_rsp", {62'd0, rsp_valid}, 64'd0);
    chk("rst_data", {16'd0, awaddr, araddr, wdata}, 64'd0);
    rst = 1'b0;

    // Zero-wait write from requester 0
    @(negedge clk);
    req_valid = 2'b01; req_we = 2'b01;
    req_addr[7:0] = 8'h10; req_wdata[31:0] = 32'hDEADBEEF;
    sb.push_back('{0, 32'h0, 1'b0});
    #1 chk("wr_grant", {62'd0, req_ready}, 64'd1);
    @(negedge clk);
    req_valid = 2'b00;
    chk("wr_aw_w_valid", {62'd0, awvalid, wvalid}, 64'd3);
    chk("wr_awaddr", {56'd0, awaddr}, 64'h10);
    chk("wr_wdata", {32'd0, wdata}, 64'hDEADBEEF);
    chk("wr_wstrb", {60'd0, wstrb}, 64'hF);
    chk("wr_no_ar", {63'd0, arvalid}, 64'd0);
    @(negedge clk);
    chk("wr_bready", {61'd0, bready, awvalid, wvalid}, 64'd4);
    @(negedge clk);
    chk("wr_rsp_at_3", {62'd0, rsp_valid}, 64'd1);
    @(negedge clk);
    chk("wr_rsp_pulse", {62'd0, rsp_valid}, 64'd0);
    model_last = 0;

    // Read with SLVERR from requester 1
    slv_rresp = RESP_SLVERR; slv_rdata = 32'h12345678;
    req_valid = 2'b10; req_we = 2'b00; req_addr[15:8] = 8'h20;
    sb.push_back('{1, 32'h12345678, 1'b1});
    #1 chk("rd_grant", {62'd0, req_ready}, 64'd2);
    @(negedge clk);
    req_valid = 2'b00;
    chk("rd_arvalid", {62'd0, arvalid, rready}, 64'd2);
    chk("rd_araddr", {56'd0, araddr}, 64'h20);
    @(negedge clk);
    chk("rd_rready", {62'd0, arvalid, rready}, 64'd1);
    @(negedge clk);
    chk("rd_rsp_at_3", {62'd0, rsp_valid}, 64'd2);
    @(negedge clk);
    chk("rd_rsp_pulse", {62'd0, rsp_valid}, 64'd0);
    slv_rresp = RESP_OKAY;
    model_last = 1;

    // Write with wready delayed four cycles
    w_lat = 4;
    req_valid = 2'b01; req_we = 2'b01;
    req_addr[7:0] = 8'h44; req_wdata[31:0] = 32'hCAFE0001;
    sb.push_back('{0, 32'h0, 1'b0});
    #1 chk("slow_w_grant", {62'd0, req_ready}, 64'd1);
    @(negedge clk);
    req_valid = 2'b00;
    chk("slow_w_p1", {61'd0, awvalid, wvalid, bready}, 64'd6);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      chk("slow_w_hold", {61'd0, awvalid, wvalid, bready}, 64'd2);
    end
    @(negedge clk);
    chk("slow_w_bready", {61'd0, awvalid, wvalid, bready}, 64'd1);
    w_lat = 0;
    repeat (2) @(negedge clk);
    model_last = 0;

    // Both requesters reading continuously
    req_valid = 2'b11; req_we = 2'b00;
    req_addr = {8'h31, 8'h30};
    for (int n = 0; n < 4; n++) begin
      got = 1'b0;
      #1;
      for (int t = 0; t < 16; t++) begin
        if (req_ready !== '0) begin got = 1'b1; break; end
        @(negedge clk);
        #1;
      end
      chk("rr_grant_seen", {63'd0, got}, 64'd1);
`ifdef AXI_ARB_FIXED_PRIORITY_EN
      exp_g = 0;
`else
      exp_g = (model_last + 1) % NR;
`endif
      chk("rr_grant_order", {62'd0, req_ready}, 64'd1 << exp_g);
      model_last = exp_g;
      slv_rdata = 32'hA5A50000 | n;
      sb.push_back('{exp_g, 32'hA5A50000 | n, 1'b0});
      @(negedge clk);
    end
    req_valid = 2'b00;
    repeat (6) @(negedge clk);

    // Reset asserted while waiting for the write response
    b_lat = 20;
    req_valid = 2'b10; req_we = 2'b10;
    req_addr[15:8] = 8'h55; req_wdata[63:32] = 32'h0BADF00D;
    #1;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    chk("abort_in_wr_b", {63'd0, bready}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_valids", {58'd0, awvalid, wvalid, arvalid, bready, rready, rsp_err}, 64'd0);
    chk("abort_rsp", {60'd0, rsp_valid, req_ready}, 64'd0);
    chk("abort_data", {16'd0, awaddr, araddr, wdata}, 64'd0);
    repeat (3) @(negedge clk);
    b_lat = 0;
    rst = 1'b0;
    req_valid = 2'b11; req_we = 2'b11;
    req_addr[7:0] = 8'h66;
    sb.push_back('{0, 32'h0, 1'b0});
    #1 chk("post_rst_grant", {62'd0, req_ready}, 64'd1);
    @(negedge clk);
    req_valid = 2'b00;
    chk("post_rst_awaddr", {56'd0, awaddr}, 64'h66);

    for (int t = 0; t < 20 && sb.size() > 0; t++) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
